mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit downstream of reg_file.

---
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/result bus between issue logic and the iterative RV32M mul/div unit.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
);
  logic                           start;
  logic                           flush;
  logic [2:0]                     op;
  logic [DATA_WIDTH-1:0]          op_a;
  logic [DATA_WIDTH-1:0]          op_b;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_in;
  logic                           busy;
  logic                           done;
  logic [DATA_WIDTH-1:0]          result;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_out;
  logic                           we;

  modport master (
    output start, flush, op, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, we
  );

  modport slave (
    input  start, flush, op, op_a, op_b, rd_in,
    output busy, done, result, rd_out, we
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, sign fix-up on the last step.
module mul_div_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = REG_FILE_ADDR_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     b_q;
  logic             neg_q;
  logic             nega_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     result_q;
  logic             done_q;

  logic             a_sgn, b_sgn, na, nb, fast;
  logic [W-1:0]     mag_a, mag_b, fast_res;
  logic [W:0]       sum, rs, diff;
  logic [2*W-1:0]   step_d, prod;
  logic [W-1:0]     fin_d;

  // Operand signedness, magnitudes and the single-cycle special cases
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (bus.op[2]) begin
      a_sgn = ~bus.op[0];
      b_sgn = ~bus.op[0];
    end else begin
      a_sgn = (bus.op[1:0] != 2'b11);
      b_sgn = ~bus.op[1];
    end
    na    = a_sgn & bus.op_a[W-1];
    nb    = b_sgn & bus.op_b[W-1];
    mag_a = na ? -bus.op_a : bus.op_a;
    mag_b = nb ? -bus.op_b : bus.op_b;

    fast     = 1'b0;
    fast_res = '0;
    if (bus.op_b == '0) begin
      fast     = 1'b1;
      fast_res = !bus.op[2] ? '0 : (bus.op[1] ? bus.op_a : '1);
    end else if (bus.op[2] && !bus.op[0] && (bus.op_b == '1) &&
                 (bus.op_a == {1'b1, {(W-1){1'b0}}})) begin
      fast     = 1'b1;
      fast_res = bus.op[1] ? '0 : bus.op_a;
    end
  end

  // One multiply or divide iteration, plus the signed result it would finish on
  always_comb begin
    sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rs     = {acc_q[2*W-1:W], acc_q[W-1]};
    diff   = rs - {1'b0, b_q};
    step_d = '0;
    if (!op_q[2])
      step_d = {sum, acc_q[W-1:1]};
    else if (!diff[W])
      step_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    else
      step_d = {rs[W-1:0], acc_q[W-2:0], 1'b0};

    prod  = neg_q ? -step_d : step_d;
    fin_d = '0;
    if (!op_q[2])
      fin_d = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    else if (op_q[1])
      fin_d = nega_q ? -step_d[2*W-1:W] : step_d[2*W-1:W];
    else
      fin_d = neg_q ? -step_d[W-1:0] : step_d[W-1:0];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_in;
            acc_q  <= {{W{1'b0}}, mag_a};
            b_q    <= mag_b;
            neg_q  <= na ^ nb;
            nega_q <= na;
            cnt_q  <= '0;
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= step_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
              result_q <= fin_d;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A flush arriving during the DONE cycle suppresses that cycle's done/we
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q & ~bus.flush;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
  assign bus.we     = done_q & ~bus.flush & (rd_q != '0);
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: table of ops with hand-computed
// results and latencies, plus sequences for stray start, flush and reset.
module tb_mul_div_unit;
  localparam int W  = 32;
  localparam int AW = 5;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM    = 3'd6, REMU  = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_WIDTH(W), .REG_FILE_ADDR_WIDTH(AW)) bus ();
  mul_div_unit #(.DATA_WIDTH(W), .REG_FILE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic [W-1:0]  res;
    int            lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] rd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.rd_in = ~rd;
  endtask

  // Edges after the accept edge until done is seen (sampled at negedge)
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] rd,
                        input logic [W-1:0] exp, input int lat);
    int n;
    accept(op, a, b, rd);
    wait_done(n);
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " result"}, bus.result, exp);
    chk({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    chk({name, " we"}, 32'(bus.we), 32'(rd != '0));
    @(negedge clk);
    chk({name, " done pulse"}, 32'(bus.done), 32'd0);
    chk({name, " idle"}, 32'(bus.busy), 32'd0);
    chk({name, " held"}, bus.result, exp);
  endtask

  initial begin
    int n;
    bit seen;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;

    vecs[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 32};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 32};
    vecs[2]  = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'h00000000, 32};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 32};
    vecs[4]  = '{MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  32'h00000001, 32};
    vecs[5]  = '{DIV,    32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFD, 32};
    vecs[6]  = '{REM,    32'hFFFFFFF9,   32'd2,        5'd7,  32'hFFFFFFFF, 32};
    vecs[7]  = '{DIVU,   32'd100,        32'd7,        5'd8,  32'd14,       32};
    vecs[8]  = '{REMU,   32'd100,        32'd7,        5'd9,  32'd2,        32};
    vecs[9]  = '{DIVU,   32'd5,          32'd0,        5'd10, 32'hFFFFFFFF, 0};
    vecs[10] = '{REM,    32'd5,          32'd0,        5'd11, 32'd5,        0};
    vecs[11] = '{DIV,    32'h80000000,   32'hFFFFFFFF, 5'd12, 32'h80000000, 0};
    vecs[12] = '{REM,    32'h80000000,   32'hFFFFFFFF, 5'd13, 32'd0,        0};
    vecs[13] = '{MULHU,  32'd12345,      32'd0,        5'd14, 32'd0,        0};
    vecs[14] = '{DIV,    32'd100,        32'hFFFFFFF9, 5'd15, 32'hFFFFFFF2, 32};
    vecs[15] = '{REM,    32'd100,        32'hFFFFFFF9, 5'd16, 32'd2,        32};
    vecs[16] = '{MULH,   32'h80000000,   32'd2,        5'd0,  32'hFFFFFFFF, 32};

    // Asynchronous reset: outputs clear without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset we", 32'(bus.we), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset rd_out", 32'(bus.rd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].res, vecs[i].lat);

    // Stray start three cycles into RUN must be ignored
    accept(MUL, 32'd7, 32'd3, 5'd1);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      bus.start = (n == 3); bus.op = DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("stray start latency", 32'(n), 32'd32);
    chk("stray start result", bus.result, 32'd21);
    @(negedge clk);
    chk("stray start no second op", 32'(bus.busy), 32'd0);

    // Flush at RUN cycle 10: no done, result untouched
    accept(DIVU, 32'd100, 32'd7, 5'd2);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("flush no done", 32'(seen), 32'd0);
    chk("flush result held", bus.result, 32'd21);
    run_op("after flush", DIVU, 32'd100, 32'd7, 5'd2, 32'd14, 32);

    // Flush during the DONE cycle of a fast-path op
    accept(DIVU, 32'd9, 32'd0, 5'd3);
    @(negedge clk);
    chk("done before flush", 32'(bus.done), 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush masks done", 32'(bus.done), 32'd0);
    chk("flush masks we", 32'(bus.we), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush in done idle", 32'(bus.busy), 32'd0);
    chk("flush in done result", bus.result, 32'hFFFFFFFF);

    // Reset mid-RUN discards everything immediately
    accept(MUL, 32'd7, 32'd3, 5'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst busy", 32'(bus.busy), 32'd0);
    chk("midrun rst done", 32'(bus.done), 32'd0);
    chk("midrun rst we", 32'(bus.we), 32'd0);
    chk("midrun rst result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("x0 dest", MUL, 32'd6, 32'd7, 5'd0, 32'd42, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
